// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   ST_F..ST_W    stage indices for the per-stage stall/flush vectors
//   div_state_e   divider handshake sequencer states
//   REG_ZERO      architectural zero register index (never a real dependency)
//   reg_hit()     "dest register is non-zero and matches either source" compare
package hazard_ctrl_pkg;

    localparam int ST_F     = 0;
    localparam int ST_D     = 1;
    localparam int ST_E     = 2;
    localparam int ST_M     = 3;
    localparam int ST_W     = 4;
    localparam int NUM_ST   = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Writes to $zero never create a dependency, so they are excluded here.
    function automatic logic reg_hit(input logic [31:0] dst,
                                     input logic [31:0] src_a,
                                     input logic [31:0] src_b);
        return (dst != 32'(REG_ZERO)) && ((dst == src_a) || (dst == src_b));
    endfunction

endpackage

// File: rtl/hazard_div_seq.sv
// Divider start/done sequencer with a watchdog.
// Ports:
//   clk, rst    core clock, synchronous active-high reset
//   div_e       E stage holds a div/divu
//   div_done    divider result valid pulse
//   hold        pipeline frozen by a bus access: state and watchdog hold
//   flush       exception/eret flush taking effect this cycle
//   div_stall   hold F/D/E and bubble M while the divide is running
//   div_start   one-cycle start pulse to the divider
//   div_abort   one-cycle cancel pulse to the divider (flush or watchdog)
//   div_err     sticky watchdog error
module hazard_div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_MAXC = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic div_e,
    input  logic div_done,
    input  logic hold,
    input  logic flush,
    output logic div_stall,
    output logic div_start,
    output logic div_abort,
    output logic div_err
);

    localparam int WDW = $clog2(DIV_MAXC + 1);

    div_state_e     state_r;
    div_state_e     state_nx_s;
    logic [WDW-1:0] wd_r;
    logic           done_pend_r;
    logic           div_err_r;
    logic           done_s;
    logic           timeout_s;
    logic           err_set_s;

    // Next state and the start/abort/stall decode.
    always_comb begin
        // A done pulse that landed while frozen is remembered so it is not lost.
        done_s     = div_done | done_pend_r;
        // wd_r counts completed BUSY cycles; this is the last allowed one.
        timeout_s  = (wd_r == WDW'(DIV_MAXC - 1));
        state_nx_s = state_r;
        div_start  = 1'b0;
        div_abort  = 1'b0;
        div_stall  = 1'b0;
        err_set_s  = 1'b0;
        if (hold) begin
            state_nx_s = state_r;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    // A div being flushed out of E must not start.
                    if (div_e && !flush) begin
                        div_start  = 1'b1;
                        div_stall  = 1'b1;
                        state_nx_s = DIV_BUSY;
                    end else begin
                        state_nx_s = DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (flush) begin
                        div_abort  = 1'b1;
                        state_nx_s = DIV_IDLE;
                    end else if (done_s) begin
                        // Stall drops now so the div leaves E with its result.
                        state_nx_s = DIV_DONE;
                    end else if (timeout_s) begin
                        div_abort  = 1'b1;
                        err_set_s  = 1'b1;
                        state_nx_s = DIV_IDLE;
                    end else begin
                        div_stall  = 1'b1;
                        state_nx_s = DIV_BUSY;
                    end
                end
                DIV_DONE: begin
                    // One dead cycle so the same div cannot start again.
                    state_nx_s = DIV_IDLE;
                end
                default: begin
                    state_nx_s = DIV_IDLE;
                end
            endcase
        end
    end

    // State, watchdog, pending-done and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= DIV_IDLE;
            wd_r        <= {WDW{1'b0}};
            done_pend_r <= 1'b0;
            div_err_r   <= 1'b0;
        end else if (hold) begin
            state_r     <= state_r;
            wd_r        <= wd_r;
            done_pend_r <= done_pend_r | ((state_r == DIV_BUSY) & div_done);
            div_err_r   <= div_err_r;
        end else begin
            state_r     <= state_nx_s;
            done_pend_r <= 1'b0;
            wd_r        <= ((state_r == DIV_BUSY) && (state_nx_s == DIV_BUSY)) ?
                           wd_r + WDW'(1) : {WDW{1'b0}};
            div_err_r   <= div_err_r | err_set_s;
        end
    end

    assign div_err = div_err_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: per-stage stall (enable
// low) and clear for the F/D/E/M/W pipeline registers.
// Ports:
//   clk, rst                    core clock, synchronous active-high reset
//   rs_d, rt_d, branch_d        D-stage sources and branch/jr operand need
//   rt_e, memtoreg_e,
//   regwrite_e, writereg_e      E-stage load/writeback info
//   memtoreg_m, writereg_m      M-stage load info
//   div_e, div_done             divider handshake inputs
//   i_stall, d_stall            bus accesses outstanding (freeze the pipe)
//   except_m                    exception/eret committing in M
//   stall_f..stall_w            per-stage hold
//   flush_d..flush_w            per-stage clear
//   div_start, div_abort,
//   div_err                     divider control and watchdog error
// Priority: rst > bus freeze > flush > divide > load-use/branch.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REGW     = 5,
    parameter int DIV_MAXC = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] rs_d,
    input  logic [REGW-1:0] rt_d,
    input  logic            branch_d,
    input  logic [REGW-1:0] rt_e,
    input  logic            memtoreg_e,
    input  logic            regwrite_e,
    input  logic [REGW-1:0] writereg_e,
    input  logic            memtoreg_m,
    input  logic [REGW-1:0] writereg_m,
    input  logic            div_e,
    input  logic            div_done,
    input  logic            i_stall,
    input  logic            d_stall,
    input  logic            except_m,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            stall_m,
    output logic            stall_w,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic            flush_w,
    output logic            div_start,
    output logic            div_abort,
    output logic            div_err
);

    logic              mem_busy_s;
    logic              flush_s;
    logic              flush_pend_r;
    logic              lwstall_s;
    logic              brstall_s;
    logic              div_stall_s;
    logic              div_start_s;
    logic              div_abort_s;
    logic              div_err_s;
    logic [ST_W:ST_F]  stall_v_s;
    logic [ST_W:ST_D]  flush_v_s;

    assign mem_busy_s = i_stall | d_stall;
    // A flush seen during a freeze is replayed on the first unfrozen cycle.
    assign flush_s    = (except_m | flush_pend_r) & ~mem_busy_s;
    assign lwstall_s  = memtoreg_e & reg_hit(32'(rt_e), 32'(rs_d), 32'(rt_d));
    assign brstall_s  = branch_d &
                        ((regwrite_e & reg_hit(32'(writereg_e), 32'(rs_d), 32'(rt_d))) |
                         (memtoreg_m & reg_hit(32'(writereg_m), 32'(rs_d), 32'(rt_d))));

    hazard_div_seq #(
        .DIV_MAXC (DIV_MAXC)
    ) u_div_seq (
        .clk       (clk),
        .rst       (rst),
        .div_e     (div_e),
        .div_done  (div_done),
        .hold      (mem_busy_s),
        .flush     (flush_s),
        .div_stall (div_stall_s),
        .div_start (div_start_s),
        .div_abort (div_abort_s),
        .div_err   (div_err_s)
    );

    // Remember an exception that arrives while the bus holds the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend_r <= 1'b0;
        end else if (mem_busy_s) begin
            flush_pend_r <= flush_pend_r | except_m;
        end else begin
            flush_pend_r <= 1'b0;
        end
    end

    // Priority mux producing the per-stage stall and clear vectors.
    always_comb begin
        stall_v_s = {NUM_ST{1'b0}};
        flush_v_s = {(NUM_ST - 1){1'b0}};
        if (rst) begin
            stall_v_s = {NUM_ST{1'b0}};
        end else if (mem_busy_s) begin
            stall_v_s = {NUM_ST{1'b1}};
        end else if (flush_s) begin
            flush_v_s = {(NUM_ST - 1){1'b1}};
        end else if (div_stall_s) begin
            stall_v_s[ST_F] = 1'b1;
            stall_v_s[ST_D] = 1'b1;
            stall_v_s[ST_E] = 1'b1;
            flush_v_s[ST_M] = 1'b1;
        end else if (lwstall_s || brstall_s) begin
            // Hold F/D and inject a bubble into E; M and W keep moving.
            stall_v_s[ST_F] = 1'b1;
            stall_v_s[ST_D] = 1'b1;
            flush_v_s[ST_E] = 1'b1;
        end else begin
            stall_v_s = {NUM_ST{1'b0}};
        end
    end

    assign stall_f   = stall_v_s[ST_F];
    assign stall_d   = stall_v_s[ST_D];
    assign stall_e   = stall_v_s[ST_E];
    assign stall_m   = stall_v_s[ST_M];
    assign stall_w   = stall_v_s[ST_W];
    assign flush_d   = flush_v_s[ST_D];
    assign flush_e   = flush_v_s[ST_E];
    assign flush_m   = flush_v_s[ST_M];
    assign flush_w   = flush_v_s[ST_W];
    assign div_start = div_start_s & ~rst;
    assign div_abort = div_abort_s & ~rst;
    assign div_err   = div_err_s & ~rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level reference model derived
// from the pipeline rules, directed scenarios with literal expectations, and
// a randomized phase.
module tb_hazard_ctrl;

    localparam int DIV_MAXC = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rt_e, writereg_e, writereg_m;
    logic       branch_d, memtoreg_e, regwrite_e, memtoreg_m;
    logic       div_e, div_done, i_stall, d_stall, except_m;
    logic       stall_f, stall_d, stall_e, stall_m, stall_w;
    logic       flush_d, flush_e, flush_m, flush_w;
    logic       div_start, div_abort, div_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: divider phase 0 idle, 1 busy, 2 done.
    int m_div = 0, m_cnt = 0;
    bit m_dp = 1'b0, m_err = 1'b0, m_fp = 1'b0;
    int n_div = 0, n_cnt = 0;
    bit n_dp = 1'b0, n_err = 1'b0, n_fp = 1'b0;

    hazard_ctrl #(.REGW(5), .DIV_MAXC(DIV_MAXC)) dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .rt_e(rt_e), .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e),
        .writereg_e(writereg_e), .memtoreg_m(memtoreg_m), .writereg_m(writereg_m),
        .div_e(div_e), .div_done(div_done), .i_stall(i_stall), .d_stall(d_stall),
        .except_m(except_m), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e),
        .flush_m(flush_m), .flush_w(flush_w), .div_start(div_start),
        .div_abort(div_abort), .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] outs();
        return {stall_w, stall_m, stall_e, stall_d, stall_f,
                flush_w, flush_m, flush_e, flush_d, div_start, div_abort, div_err};
    endfunction

    // Compare process: expected outputs from the rules, checked mid-cycle.
    always @(negedge clk) begin : model_cmp
        bit       mb, fl, lw, br, dstl, est, eab;
        bit [4:0] es;
        bit [3:0] ef;
        es = 5'd0; ef = 4'd0; est = 1'b0; eab = 1'b0; dstl = 1'b0;
        n_div = m_div; n_cnt = m_cnt; n_dp = m_dp; n_err = m_err; n_fp = m_fp;
        mb = i_stall | d_stall;
        fl = (except_m | m_fp) & !mb;
        lw = memtoreg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
        br = branch_d &&
             ((regwrite_e && writereg_e != 0 && (writereg_e == rs_d || writereg_e == rt_d)) ||
              (memtoreg_m && writereg_m != 0 && (writereg_m == rs_d || writereg_m == rt_d)));
        if (rst) begin
            n_div = 0; n_cnt = 0; n_dp = 1'b0; n_err = 1'b0; n_fp = 1'b0;
        end else if (mb) begin
            es = 5'b11111;
            if (except_m) n_fp = 1'b1;
            if (m_div == 1 && div_done) n_dp = 1'b1;
        end else begin
            n_fp = 1'b0;
            n_dp = 1'b0;
            if (m_div == 0) begin
                if (div_e && !fl) begin est = 1'b1; dstl = 1'b1; n_div = 1; n_cnt = 0; end
            end else if (m_div == 1) begin
                if (fl) begin eab = 1'b1; n_div = 0; n_cnt = 0; end
                else if (div_done || m_dp) begin n_div = 2; n_cnt = 0; end
                else if (m_cnt + 1 == DIV_MAXC) begin
                    eab = 1'b1; n_err = 1'b1; n_div = 0; n_cnt = 0;
                end else begin dstl = 1'b1; n_cnt = m_cnt + 1; end
            end else begin
                n_div = 0;
            end
            if (fl) ef = 4'b1111;
            else if (dstl) begin es = 5'b00111; ef = 4'b0100; end
            else if (lw || br) begin es = 5'b00011; ef = 4'b0010; end
        end
        check("stall_vec", {27'd0, stall_w, stall_m, stall_e, stall_d, stall_f}, {27'd0, es});
        check("flush_vec", {28'd0, flush_w, flush_m, flush_e, flush_d}, {28'd0, ef});
        check("div_ctl", {29'd0, div_start, div_abort, div_err},
              {29'd0, est, eab, (rst ? 1'b0 : m_err)});
    end

    // Commit the model's next state on the active edge.
    always @(posedge clk) begin
        m_div <= n_div; m_cnt <= n_cnt; m_dp <= n_dp; m_err <= n_err; m_fp <= n_fp;
    end

    task automatic clr_in();
        rs_d = 5'd0; rt_d = 5'd0; rt_e = 5'd0; writereg_e = 5'd0; writereg_m = 5'd0;
        branch_d = 1'b0; memtoreg_e = 1'b0; regwrite_e = 1'b0; memtoreg_m = 1'b0;
        div_e = 1'b0; div_done = 1'b0; i_stall = 1'b0; d_stall = 1'b0; except_m = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int stall_cnt, start_cnt, first_abort;
        clr_in();
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", {20'd0, outs()}, 32'd0);
        nxt(); nxt();
        rst = 1'b0;

        // Load-use, then rt_e == 0 never stalls.
        memtoreg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
        @(negedge clk);
        check("lw_stall", {28'd0, stall_f, stall_d, stall_e, flush_e}, 32'hD);
        nxt();
        rt_e = 5'd0;
        @(negedge clk);
        check("lw_r0_no_stall", {29'd0, stall_f, stall_d, flush_e}, 32'd0);
        nxt();

        // Branch operands from E then from a load in M.
        clr_in(); branch_d = 1'b1; rs_d = 5'd3; regwrite_e = 1'b1; writereg_e = 5'd3;
        @(negedge clk);
        check("br_e_stall", {29'd0, stall_f, stall_d, flush_e}, 32'h7);
        nxt();
        regwrite_e = 1'b0; writereg_e = 5'd0; memtoreg_m = 1'b1; writereg_m = 5'd3;
        @(negedge clk);
        check("br_m_stall", {29'd0, stall_f, stall_d, flush_e}, 32'h7);
        nxt();
        clr_in();
        @(negedge clk);
        check("br_release", {29'd0, stall_f, stall_d, flush_e}, 32'd0);
        nxt();

        // Divide completing 33 cycles after start.
        div_e = 1'b1; stall_cnt = 0; start_cnt = 0;
        for (int c = 0; c <= 34; c++) begin
            div_done = (c == 33);
            @(negedge clk);
            stall_cnt += int'(stall_e);
            start_cnt += int'(div_start);
            if (c == 0)  check("div_start_c0", {31'd0, div_start}, 32'd1);
            if (c == 33) check("div_release", {31'd0, stall_e}, 32'd0);
            nxt();
        end
        check("div_stall_cycles", 32'(stall_cnt), 32'd33);
        check("div_start_count", 32'(start_cnt), 32'd1);
        clr_in();
        nxt();

        // Exception during a data-bus freeze is held until release.
        d_stall = 1'b1; except_m = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("freeze", {23'd0, outs() >> 3}, {23'd0, 5'b11111, 4'b0000});
            nxt();
        end
        d_stall = 1'b0; except_m = 1'b0;
        @(negedge clk);
        check("flush_release", {23'd0, outs() >> 3}, {23'd0, 5'b00000, 4'b1111});
        nxt();
        @(negedge clk);
        check("flush_once", {28'd0, flush_w, flush_m, flush_e, flush_d}, 32'd0);
        nxt();

        // Exception and div_done together while busy: abort wins.
        div_e = 1'b1;
        nxt(); nxt(); nxt(); nxt();
        except_m = 1'b1; div_done = 1'b1;
        @(negedge clk);
        check("abort_flush", {27'd0, div_abort, flush_w, flush_m, flush_e, flush_d}, 32'h1F);
        nxt();
        clr_in();
        @(negedge clk);
        check("abort_idle", {29'd0, div_start, stall_e, div_abort}, 32'd0);
        nxt();
        div_e = 1'b1;
        @(negedge clk);
        check("restart_after_abort", {31'd0, div_start}, 32'd1);
        nxt();
        div_e = 1'b0; div_done = 1'b1;
        nxt();
        div_done = 1'b0;
        nxt();

        // Watchdog: no div_done ever arrives.
        div_e = 1'b1; first_abort = -1;
        for (int c = 0; c <= 41; c++) begin
            if (c == 41) div_e = 1'b0;
            @(negedge clk);
            if (div_abort && first_abort < 0) first_abort = c;
            if (c == 40) check("err_not_yet", {31'd0, div_err}, 32'd0);
            if (c == 41) check("div_err_set", {31'd0, div_err}, 32'd1);
            nxt();
        end
        check("abort_cycle", 32'(first_abort), 32'd40);

        // Reset in the middle of a busy divide.
        div_e = 1'b1;
        nxt(); nxt();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", {20'd0, outs()}, 32'd0);
        nxt();
        rst = 1'b0; div_e = 1'b0;
        @(negedge clk);
        check("after_rst", {20'd0, outs()}, 32'd0);
        nxt();
        div_e = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {31'd0, div_start}, 32'd1);
        nxt();
        clr_in(); rst = 1'b1;
        nxt();
        rst = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            rs_d       = 5'($urandom_range(0, 3));
            rt_d       = 5'($urandom_range(0, 3));
            rt_e       = 5'($urandom_range(0, 3));
            writereg_e = 5'($urandom_range(0, 3));
            writereg_m = 5'($urandom_range(0, 3));
            branch_d   = ($urandom_range(0, 3) == 0);
            memtoreg_e = ($urandom_range(0, 3) == 0);
            regwrite_e = ($urandom_range(0, 1) == 0);
            memtoreg_m = ($urandom_range(0, 3) == 0);
            div_e      = ($urandom_range(0, 3) == 0);
            div_done   = ($urandom_range(0, 11) == 0);
            i_stall    = ($urandom_range(0, 7) == 0);
            d_stall    = ($urandom_range(0, 7) == 0);
            except_m   = ($urandom_range(0, 19) == 0);
            nxt();
        end

        clr_in();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
